io_port_ctrl: RTL

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_pkg.sv | 14 +
 rtl/io_port_ctrl_if.sv | 26 ++
 rtl/io_sync_fifo.sv | 59 +++++
 rtl/io_port_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths, FIFO depth default and output-FSM state type
// Purpose: common definitions imported by the IO port controller files.
//   DATA_W         : byte width of every data path
//   FIFO_DEPTH_DEF : default input-FIFO depth in bytes
//   out_state_t    : output FSM states (IDLE = OUTR free, BUSY = OUTR holding a byte)
package io_pkg;
   localparam int DATA_W         = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } out_state_t;
endpackage

// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - byte stream bundle between IO port controller and devices
// Purpose: groups the keyboard/host input stream and the printer output stream.
//   in_data/in_valid/in_ready    : input byte stream into the controller FIFO
//   out_data/out_valid/out_ready : OUTR byte stream towards the printer sink
//   master : device side (drives input bytes and the sink ready)
//   slave  : controller side
interface io_port_ctrl_if;
   import io_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock byte FIFO feeding the INPR register
// Purpose: buffers input bytes until the processor consumes them.
//   clk, rst_n      : clock and asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data  : push a byte (ignored while full)
//   rd_en, rd_data  : pop the head (ignored while empty); rd_data is the current head
//   full, empty     : occupancy flags
//   count           : number of bytes held, 0..DEPTH
module io_sync_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - basic-computer IO port: input FIFO/INPR/FGI, OUTR/FGO, interrupt logic
// Purpose: bridges byte streams to the processor's INPR/OUTR registers and raises R.
//   clk, CLR_GLOBAL : clock and asynchronous active-low reset
//   bus (slave)     : input byte stream (into FIFO) and OUTR stream to printer sink
//   outt_INPR, FGI  : input register and input flag
//   FGO             : output flag (1 while OUTR is free)
//   IEN, R          : interrupt enable and interrupt request flip-flops
//   ac_low          : AC[7:0], loaded into OUTR on out_load
//   inp_ack, out_load, ion, iof, int_ack : processor instruction/cycle pulses
//   not_t012        : processor timing is outside T0..T2
//   ovr_err         : sticky, out_load arrived while OUTR was still busy
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              CLR_GLOBAL,
   io_port_ctrl_if.slave     bus,
   output logic [DATA_W-1:0] outt_INPR,
   output logic              FGI,
   output logic              FGO,
   output logic              IEN,
   output logic              R,
   input  logic [DATA_W-1:0] ac_low,
   input  logic              inp_ack,
   input  logic              out_load,
   input  logic              ion,
   input  logic              iof,
   input  logic              not_t012,
   input  logic              int_ack,
   output logic              ovr_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_wr;
   logic              fifo_pop;

   out_state_t        state_q;
   out_state_t        state_d;
   logic              load_outr;
   logic [DATA_W-1:0] out_data_q;

   // Gating with CLR_GLOBAL keeps devices from handing over bytes during reset.
   assign bus.in_ready = CLR_GLOBAL && !fifo_full;
   assign fifo_wr      = bus.in_valid && bus.in_ready;
   // INPR only refills once the processor has consumed the previous byte.
   assign fifo_pop     = !FGI && !fifo_empty;

   io_sync_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (CLR_GLOBAL),
      .wr_en   (fifo_wr),
      .wr_data (bus.in_data),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   a_fifo_flags: assert property (@(posedge clk) disable iff (!CLR_GLOBAL)
      fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

   // Input side: INPR/FGI handshake and interrupt flip-flops.
   always_ff @(posedge clk or negedge CLR_GLOBAL) begin
      if (!CLR_GLOBAL) begin
         outt_INPR <= '0;
         FGI       <= 1'b0;
         IEN       <= 1'b0;
         R         <= 1'b0;
         ovr_err   <= 1'b0;
      end else begin
         if (fifo_pop) begin
            outt_INPR <= fifo_head;
            FGI       <= 1'b1;
         end else if (inp_ack && FGI) begin
            FGI       <= 1'b0;
         end

         if (int_ack)    IEN <= 1'b0;
         else if (iof)   IEN <= 1'b0;
         else if (ion)   IEN <= 1'b1;

         if (int_ack)                                  R <= 1'b0;
         else if (not_t012 && IEN && (FGI || FGO))     R <= 1'b1;

         if (out_load && state_q == BUSY) ovr_err <= 1'b1;
      end
   end

   // Output FSM state and OUTR register.
   always_ff @(posedge clk or negedge CLR_GLOBAL) begin
      if (!CLR_GLOBAL) begin
         state_q    <= IDLE;
         out_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_outr) out_data_q <= ac_low;
      end
   end

   always_comb begin
      state_d   = state_q;
      load_outr = 1'b0;
      case (state_q)
         IDLE: begin
            if (out_load) begin
               state_d   = BUSY;
               load_outr = 1'b1;
            end
         end
         BUSY: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign FGO           = (state_q == IDLE);
   assign bus.out_valid = (state_q == BUSY);
   assign bus.out_data  = out_data_q;
endmodule
